// File: rtl/hc_sr04_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hc_sr04_pkg - shared widths, filter state and helpers            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hc_sr04_pkg;

  localparam int DIST_W = 14;
  localparam int MISS_W = 8;
  localparam int REJ_W  = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } filt_state_e;

  // Magnitude of a - b, computed one bit wider so the sign is never lost.
  function automatic logic [DIST_W:0] abs_diff(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b);
    logic [DIST_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DIST_W] ? (~d + 1'b1) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc_sr04_avg_ring.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hc_sr04_avg_ring - sample ring buffer with running sum           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hc_sr04_avg_ring #(
  parameter int DW       = 14,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   push,
  input  logic [DW-1:0]          data,
  output logic [DW+AVG_LOG2-1:0] sum,
  output logic [DW+AVG_LOG2-1:0] sum_nxt
);

  localparam int DEPTH = 2**AVG_LOG2;
  localparam int SW    = DW + AVG_LOG2;

  logic [DW-1:0]       ring_q [DEPTH];
  logic [AVG_LOG2-1:0] ptr_q;
  logic [AVG_LOG2-1:0] ptr_d;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_d;

  always_comb begin
    sum_d = sum_q;
    ptr_d = ptr_q;
    if (clear) begin
      sum_d = '0;
      ptr_d = '0;
    end else if (load) begin
      sum_d = SW'(data) << AVG_LOG2;
      ptr_d = '0;
    end else if (push) begin
      sum_d = sum_q - SW'(ring_q[ptr_q]) + SW'(data);
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      sum_q <= sum_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (clear) begin
          ring_q[i] <= '0;
        end else if (load || (push && (ptr_q == AVG_LOG2'(i)))) begin
          ring_q[i] <= data;
        end
      end
    end
  end

  assign sum     = sum_q;
  assign sum_nxt = sum_d;

endmodule
`default_nettype wire

// File: rtl/hc_sr04_distance_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hc_sr04_distance_filter - outlier-rejecting averager, near flag  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hc_sr04_distance_filter
  import hc_sr04_pkg::*;
#(
  parameter int DW           = DIST_W,
  parameter int AVG_LOG2     = 2,
  parameter int JUMP_MAX     = 50,
  parameter int REJECT_LIMIT = 3
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              clear,
  input  logic [DW-1:0]     sample_in,
  input  logic              sample_valid,
  input  logic [DW-1:0]     th_near,
  input  logic [DW-1:0]     hyst,
  output logic [DW-1:0]     filt_out,
  output logic              filt_valid,
  output logic              near,
  output logic              near_irq,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [REJ_W-1:0]  reject_cnt
);

  localparam int                SW       = DW + AVG_LOG2;
  localparam logic [DIST_W:0]   JUMP_LIM = (DIST_W + 1)'(JUMP_MAX);
  localparam logic [REJ_W-1:0]  REJ_LIM  = REJ_W'(REJECT_LIMIT);

  filt_state_e        state_q, state_d;
  logic               s1_valid_q, s1_valid_d;
  logic [DW-1:0]      s1_data_q;
  logic [REJ_W-1:0]   rej_q, rej_d, rej_inc;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [DW-1:0]      filt_q, filt_d, filt_avg;
  logic               fvalid_q, fvalid_d;
  logic               near_q, near_d;
  logic               irq_q, irq_d;
  logic               load, push, upd;
  logic [DIST_W:0]    dev;
  logic [DW:0]        clr_level;
  logic [SW-1:0]      sum_cur, sum_nxt;

  hc_sr04_avg_ring #(
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clear   (clear),
    .load    (load),
    .push    (push),
    .data    (s1_data_q),
    .sum     (sum_cur),
    .sum_nxt (sum_nxt)
  );

  // Deviation is against the current filt_out register, which may lag one
  // update when samples arrive back-to-back.
  assign dev       = abs_diff(filt_q, s1_data_q);
  assign rej_inc   = rej_q + 1'b1;
  assign filt_avg  = DW'(sum_nxt >> AVG_LOG2);
  assign clr_level = {1'b0, th_near} + {1'b0, hyst};

  always_comb begin
    state_d    = state_q;
    rej_d      = rej_q;
    miss_d     = miss_q;
    load       = 1'b0;
    push       = 1'b0;
    upd        = 1'b0;
    s1_valid_d = sample_valid & ~clear;

    if (s1_valid_q && !clear) begin
      if (s1_data_q == '0) begin
        if (miss_q != '1) miss_d = miss_q + 1'b1;
      end else if (state_q == EMPTY) begin
        load    = 1'b1;
        rej_d   = '0;
        state_d = RUN;
        upd     = 1'b1;
      end else if (dev <= JUMP_LIM) begin
        push  = 1'b1;
        rej_d = '0;
        upd   = 1'b1;
      end else if (rej_inc == REJ_LIM) begin
        load  = 1'b1;
        rej_d = '0;
        upd   = 1'b1;
      end else begin
        rej_d = rej_inc;
      end
    end

    if (clear) begin
      state_d = EMPTY;
      rej_d   = '0;
    end
  end

  always_comb begin
    filt_d   = filt_q;
    near_d   = near_q;
    irq_d    = 1'b0;
    fvalid_d = upd;

    if (upd) begin
      filt_d = filt_avg;
      if (filt_avg < th_near) begin
        near_d = 1'b1;
      end else if ({1'b0, filt_avg} > clr_level) begin
        near_d = 1'b0;
      end
      irq_d = near_d & ~near_q;
    end

    if (clear) begin
      filt_d   = '0;
      near_d   = 1'b0;
      irq_d    = 1'b0;
      fvalid_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rej_q      <= '0;
      miss_q     <= '0;
      filt_q     <= '0;
      fvalid_q   <= 1'b0;
      near_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= sample_in;
      rej_q      <= rej_d;
      miss_q     <= miss_d;
      filt_q     <= filt_d;
      fvalid_q   <= fvalid_d;
      near_q     <= near_d;
      irq_q      <= irq_d;
    end
  end

  assign filt_out   = filt_q;
  assign filt_valid = fvalid_q;
  assign near       = near_q;
  assign near_irq   = irq_q;
  assign miss_cnt   = miss_q;
  assign reject_cnt = rej_q;

endmodule
`default_nettype wire
